e_mdu: RTL and testbench

E_MDU -- requirements
Module: e_mdu

---
 rtl/e_mdu.sv | 141 ++++++++++++++
 tb/tb_e_mdu.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit with HI/LO registers.
// Multi-cycle mult/div hold busy for a fixed latency; mthi/mtlo write in one edge.
module e_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Req,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_in,
    input  logic [31:0] rt_in,
    output logic        busy,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [2:0]  op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [31:0] hi;
    logic [31:0] lo;

    logic        accept;
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] q_u;
    logic [31:0] r_u;
    logic        b_zero;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    assign busy   = (state == RUN);
    assign hi_out = hi;
    assign lo_out = lo;
    assign accept = start & ~Req & (state == IDLE);
    assign b_zero = (b_q == 32'd0);

    always_comb begin
        prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
        prod_u = {32'd0, a_q} * {32'd0, b_q};
        // Signed divide on magnitudes so INT_MIN / -1 wraps cleanly.
        a_mag  = a_q[31] ? -a_q : a_q;
        b_mag  = b_q[31] ? -b_q : b_q;
        q_mag  = 32'd0;
        r_mag  = 32'd0;
        q_u    = 32'd0;
        r_u    = 32'd0;
        if (!b_zero) begin
            q_mag = a_mag / b_mag;
            r_mag = a_mag % b_mag;
            q_u   = a_q / b_q;
            r_u   = a_q % b_q;
        end
        res_hi = hi;
        res_lo = lo;
        case (op_q)
            OP_MULT:  {res_hi, res_lo} = prod_s;
            OP_MULTU: {res_hi, res_lo} = prod_u;
            OP_DIV: begin
                if (!b_zero) begin
                    res_lo = (a_q[31] ^ b_q[31]) ? -q_mag : q_mag;
                    res_hi = a_q[31] ? -r_mag : r_mag;
                end
            end
            OP_DIVU: begin
                if (!b_zero) begin
                    res_lo = q_u;
                    res_hi = r_u;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
            op_q  <= 3'd0;
            a_q   <= 32'd0;
            b_q   <= 32'd0;
            hi    <= 32'd0;
            lo    <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        case (op)
                            OP_MULT, OP_MULTU: begin
                                state <= RUN;
                                cnt   <= 4'(MULT_CYCLES);
                                op_q  <= op;
                                a_q   <= rs_in;
                                b_q   <= rt_in;
                            end
                            OP_DIV, OP_DIVU: begin
                                state <= RUN;
                                cnt   <= 4'(DIV_CYCLES);
                                op_q  <= op;
                                a_q   <= rs_in;
                                b_q   <= rt_in;
                            end
                            OP_MTHI: hi <= rs_in;
                            OP_MTLO: lo <= rs_in;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    if (cnt == 4'd1) begin
                        state <= IDLE;
                        cnt   <= 4'd0;
                        hi    <= res_hi;
                        lo    <= res_lo;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_e_mdu.sv
// Scoreboard bench for e_mdu: per-edge expectations from an arithmetic model,
// checked by an independent monitor on the falling edge.
module tb_e_mdu;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        Req = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] rs_in = 32'd0;
    logic [31:0] rt_in = 32'd0;
    logic        busy;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    e_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .Req(Req), .start(start), .op(op),
        .rs_in(rs_in), .rt_in(rt_in), .busy(busy),
        .hi_out(hi_out), .lo_out(lo_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          when;
        logic        busy;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    int          busy_end = -1;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] ref_op(input logic [2:0] o,
                                           input logic [31:0] a, b, h, l);
        longint sa = longint'($signed(a));
        longint sb2 = longint'($signed(b));
        longint ua = longint'({32'd0, a});
        longint ub = longint'({32'd0, b});
        longint p;
        longint q;
        longint r;
        case (o)
            3'd1: begin p = sa * sb2; return p; end
            3'd2: begin p = ua * ub; return p; end
            3'd3: begin
                if (b == 32'd0) return {h, l};
                q = sa / sb2;
                r = sa % sb2;
                return {r[31:0], q[31:0]};
            end
            3'd4: begin
                if (b == 32'd0) return {h, l};
                q = ua / ub;
                r = ua % ub;
                return {r[31:0], q[31:0]};
            end
            default: return {h, l};
        endcase
    endfunction

    task automatic push(input int w, input logic bz, input logic [31:0] h, l);
        exp_t x;
        x.when = w; x.busy = bz; x.hi = h; x.lo = l;
        sb.push_back(x);
    endtask

    task automatic step(input logic rst_v, input logic s, input logic rq,
                        input logic [2:0] o, input logic [31:0] a, b);
        int e;
        int n;
        logic [63:0] r;
        @(negedge clk);
        reset = rst_v; start = s; Req = rq; op = o; rs_in = a; rt_in = b;
        @(posedge clk);
        #1;
        e = cyc;
        if (rst_v) begin
            m_hi = 32'd0; m_lo = 32'd0; busy_end = -1;
            push(e, 1'b0, 32'd0, 32'd0);
        end else if (e <= busy_end) begin
            // edge already covered by an in-flight operation
        end else if (s && !rq && o >= 3'd1 && o <= 3'd4) begin
            n = (o <= 3'd2) ? MC : DC;
            r = ref_op(o, a, b, m_hi, m_lo);
            for (int k = 0; k < n; k++) push(e + k, 1'b1, m_hi, m_lo);
            {m_hi, m_lo} = r;
            push(e + n, 1'b0, m_hi, m_lo);
            busy_end = e + n;
        end else begin
            if (s && !rq && o == 3'd5) m_hi = a;
            if (s && !rq && o == 3'd6) m_lo = a;
            push(e, 1'b0, m_hi, m_lo);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 3'd0, $urandom, $urandom);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin : monitor
        exp_t x;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].when < cyc) begin
                x = sb.pop_front();
                vectors++;
                miscompares++;
                $display("FAIL stale cyc%0d: entry for cyc%0d never checked", cyc, x.when);
            end
            while (sb.size() > 0 && sb[0].when == cyc) begin
                x = sb.pop_front();
                vectors++;
                if (busy !== x.busy || hi_out !== x.hi || lo_out !== x.lo) begin
                    miscompares++;
                    $display("FAIL cyc%0d busy/hi/lo got %b/%h/%h want %b/%h/%h",
                             cyc, busy, hi_out, lo_out, x.busy, x.hi, x.lo);
                end
            end
        end
    end

    initial begin : stim
        int guard;
        #3;
        vectors++;
        if (busy !== 1'b0 || hi_out !== 32'd0 || lo_out !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_init busy/hi/lo got %b/%h/%h want 0/0/0", busy, hi_out, lo_out);
        end
        repeat (2) @(posedge clk);
        // first edge out of reset accepts
        step(1'b0, 1'b1, 1'b0, 3'd5, 32'h1111_2222, 32'd0);
        // signed / unsigned multiply
        step(1'b0, 1'b1, 1'b0, 3'd1, 32'hFFFF_FFFE, 32'd3);
        idle(MC);
        step(1'b0, 1'b1, 1'b0, 3'd2, 32'hFFFF_FFFE, 32'd3);
        idle(MC);
        // signed divide, divide by zero, overflow case
        step(1'b0, 1'b1, 1'b0, 3'd3, 32'hFFFF_FFF9, 32'd2);
        idle(DC);
        step(1'b0, 1'b1, 1'b0, 3'd4, 32'd7, 32'd0);
        idle(DC);
        step(1'b0, 1'b1, 1'b0, 3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        idle(DC);
        // back-to-back moves
        step(1'b0, 1'b1, 1'b0, 3'd5, 32'h1234_5678, 32'd0);
        step(1'b0, 1'b1, 1'b0, 3'd6, 32'h9ABC_DEF0, 32'd0);
        // Req kills new op, but not in-flight op
        step(1'b0, 1'b1, 1'b1, 3'd1, 32'd9, 32'd9);
        step(1'b0, 1'b1, 1'b1, 3'd5, 32'hDEAD_BEEF, 32'd0);
        step(1'b0, 1'b1, 1'b0, 3'd1, 32'd100, 32'hFFFF_FFF6);
        step(1'b0, 1'b0, 1'b0, 3'd0, 32'd1, 32'd1);
        step(1'b0, 1'b0, 1'b1, 3'd0, 32'd2, 32'd2);
        idle(MC);
        // start while busy is ignored; operands changing after accept
        step(1'b0, 1'b1, 1'b0, 3'd1, 32'd7, 32'd6);
        step(1'b0, 1'b0, 1'b0, 3'd0, 32'd55, 32'd66);
        step(1'b0, 1'b0, 1'b0, 3'd0, 32'd55, 32'd66);
        step(1'b0, 1'b1, 1'b0, 3'd4, 32'd100, 32'd3);
        step(1'b0, 1'b1, 1'b0, 3'd6, 32'd1, 32'd3);
        idle(MC);
        // reserved op
        step(1'b0, 1'b1, 1'b0, 3'd7, 32'd1, 32'd2);
        for (int i = 0; i < 400; i++)
            step(1'b0, $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                 3'($urandom_range(0, 7)), pick(), pick());
        idle(DC + 1);
        // asynchronous reset in the middle of a divide
        step(1'b0, 1'b1, 1'b0, 3'd5, 32'hA5A5_A5A5, 32'd0);
        step(1'b0, 1'b1, 1'b0, 3'd3, 32'd1000, 32'd7);
        idle(3);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        vectors++;
        if (busy !== 1'b0 || hi_out !== 32'd0 || lo_out !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_async busy/hi/lo got %b/%h/%h want 0/0/0", busy, hi_out, lo_out);
        end
        while (sb.size() > 0 && sb[$].when > cyc) void'(sb.pop_back());
        m_hi = 32'd0; m_lo = 32'd0; busy_end = -1;
        step(1'b1, 1'b1, 1'b0, 3'd5, 32'h7777_7777, 32'd0);
        idle(DC + 2);
        step(1'b0, 1'b1, 1'b0, 3'd6, 32'h0BAD_F00D, 32'd0);
        for (int i = 0; i < 60; i++)
            step(1'b0, $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                 3'($urandom_range(0, 7)), pick(), pick());
        guard = 0;
        while (sb.size() > 0 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        #1;
        if (sb.size() > 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
